encode80_7: RTL and testbench
=============================

// Module: encode80_7
// PURPOSE
//   Pipelined one-hot to binary encoder: 80-bit one-hot vector in, 7-bit index out.
//   It is the inverse of the 7->80 one-hot decoder, and the two are used as a pair on
//   select/grant buses, so decode(k) -> encode80_7 returns k.
//   It has a valid/ready stream interface on both sides and flags all-zero and
//   multi-hot inputs.
//   It also keeps a saturating error counter that software can read.
// PARAMETERS
//   N_IN     80     input vector width
//   IDX_W    7      output index width
//   GROUP    8      bits per first-stage group encoder (N_IN/GROUP = 10 groups)
//   ERR_W    16     width of err_cnt
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      reset, asynchronous assert, active-low
//   in_valid   in   1      in_vec valid
//   in_ready   out  1      block accepts in_vec this cycle
//   in_vec     in   80     one-hot select vector, bit k = index k
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_idx    out  7      encoded index (lowest set bit); 7'h7F when in_vec == 0
//   out_zero   out  1      input had no bit set
//   out_multi  out  1      input had more than one bit set
//   clr_err    in   1      synchronous clear of err_cnt
//   err_cnt    out  16     count of transferred results with out_zero|out_multi
// BEHAVIOUR
//   - Reset (rst_n low, async): s1_valid=0, s2_valid=0, out_valid=0, out_idx=0,
//     out_zero=0, out_multi=0, err_cnt=0. In-flight data is discarded, never replayed.
//   - Transfers: an input transfer happens when in_valid&in_ready. An output transfer
//     happens when out_valid&out_ready.
//   - Pipeline: 2 register stages, latency 2 cycles with no stall, throughput 1/cycle.
//   - Stage 1, per group g=0..9, registered:
//       any[g]   = |grp
//       lidx[g]  = lowest set bit position in grp (3b)
//       gmult[g] = more than one bit set in grp
//   - Stage 2, registered and driving the outputs directly:
//       g0        = lowest g with any[g]
//       out_idx   = g0*8 + lidx[g0]
//       out_zero  = ~|any
//       out_multi = |gmult OR (popcount(any) > 1)
//       if out_zero, out_idx = 7'h7F
//   - Priority: the lowest set index wins. Example: bits 5 and 70 set -> idx 5, multi=1.
//   - Flow control:
//       s2_adv   = ~s2_valid | out_ready
//       s1_adv   = ~s1_valid | s2_adv
//       in_ready = s1_adv (combinational from out_ready; no skid buffer)
//   - Stall: while out_valid & ~out_ready, out_idx/out_zero/out_multi hold stable and
//     s2 does not change. s1 holds if it is occupied.
//   - Bubbles: a stage whose advance is true and whose upstream is empty loads valid=0.
//     Data payload registers may hold stale values while valid=0.
//   - err_cnt:
//       +1 on each output transfer with (out_zero|out_multi)
//       saturates at 16'hFFFF
//       clr_err sets it to 0 next cycle
//       clr_err together with an error transfer gives 0 (clear wins)
//   - Arithmetic: g0*8 + lidx is formed as {g0[3:0], lidx[2:0]}. It needs no adder,
//     and the max valid result is 79.
// STRUCTURE
//   - Package encode80_7_pkg holds:
//       N_IN, IDX_W, GROUP, N_GRP = N_IN/GROUP, IDX_NONE = 7'h7F
//       typedef logic [IDX_W-1:0] idx_t
//       typedef struct {any, lidx, gmult} grp_enc_t
//   - Sub-module encode8_3: combinational 8->3 lowest-bit encoder with any/multi
//     outputs, instantiated N_GRP times in stage 1.
//   - Stage 2 combine logic and err_cnt stay in the top module.
// TESTING
//   1. Round trip: in_vec = 1<<k for k = 0..79 back-to-back, out_ready=1.
//      Expect out_idx=k two cycles after accept, zero=multi=0, err_cnt stays 0,
//      in_ready stays 1.
//   2. Zero: in_vec = 0.
//      Expect out_idx=7'h7F, out_zero=1, out_multi=0, err_cnt 0->1.
//   3. Multi-hot, two cases:
//      a. Bits {5,70}: expect out_idx=5, out_multi=1.
//      b. Bits {3,4}, same group: expect out_idx=3, out_multi=1. err_cnt +2 total.
//   4. Backpressure: out_ready=0 for 6 cycles with in_valid=1 offering k = 10, 11, 12...
//      Expect exactly 2 accepted before in_ready=0, outputs stable while stalled.
//      On release, the sequence 10, 11, 12... comes out in order with no loss or dup.
//   5. Saturation/clear: force 65537 error transfers.
//      Expect err_cnt=16'hFFFF, then clr_err with a simultaneous error transfer gives
//      err_cnt=0.
//   6. Reset mid-stream: with both stages valid, drop rst_n between clock edges.
//      Expect out_valid=0 immediately (async). After release, the first out_valid is
//      only for new input.

Source files
------------

// File: rtl/encode80_7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : encode80_7_pkg
// Description : Shared widths, constants and types for the 80->7 one-hot
//               encoder pipeline and its 8->3 group encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package encode80_7_pkg;

    localparam int N_IN   = 80;             // input vector width
    localparam int IDX_W  = 7;              // output index width
    localparam int GROUP  = 8;              // bits per first-stage group
    localparam int N_GRP  = N_IN / GROUP;   // number of groups (10)
    localparam int ERR_W  = 16;             // error counter width
    localparam int LIDX_W = 3;              // index width inside a group
    localparam int GIDX_W = IDX_W - LIDX_W; // group number width

    localparam logic [IDX_W-1:0] IDX_NONE = 7'h7F;

    typedef logic [IDX_W-1:0] idx_t;

    // Stage-1 summary of one 8-bit group
    typedef struct packed {
        logic              any;
        logic [LIDX_W-1:0] lidx;
        logic              gmult;
    } grp_enc_t;

endpackage
`default_nettype wire

// File: rtl/encode80_7_encode8_3.sv
`default_nettype none
// ============================================================================
// Module      : encode8_3
// Description : Combinational 8->3 lowest-set-bit encoder.
//   grp   in  [7:0]  group slice of the one-hot vector
//   any   out        at least one bit set
//   lidx  out [2:0]  position of the lowest set bit (0 when grp == 0)
//   multi out        more than one bit set
// Revision    : 1.0 - initial release
// ============================================================================
module encode8_3
    import encode80_7_pkg::*;
(
    input  logic [GROUP-1:0]  grp,
    output logic              any,
    output logic [LIDX_W-1:0] lidx,
    output logic              multi
);

    always_comb begin
        lidx = '0;
        // Scan from the top so the lowest set bit is the last one written
        for (int b = GROUP - 1; b >= 0; b--) begin
            if (grp[b]) begin
                lidx = LIDX_W'(b);
            end
        end
        any   = |grp;
        // Clearing the lowest set bit leaves something only if two or more were set
        multi = |(grp & (grp - GROUP'(1)));
    end

endmodule
`default_nettype wire

// File: rtl/encode80_7.sv
`default_nettype none
// ============================================================================
// Module      : encode80_7
// Description : Two-stage pipelined 80-bit one-hot to 7-bit binary encoder
//               with valid/ready handshakes and a saturating error counter.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake, in_vec[79:0] payload
//   out_valid/out_ready  output handshake
//   out_idx[6:0]         lowest set index, 7'h7F when input was zero
//   out_zero/out_multi   input had no bit / more than one bit set
//   clr_err              synchronous clear of err_cnt
//   err_cnt[15:0]        saturating count of transferred error results
// Revision    : 1.0 - initial release
// ============================================================================
module encode80_7
    import encode80_7_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_zero,
    output logic             out_multi,
    input  logic             clr_err,
    output logic [ERR_W-1:0] err_cnt
);

    // ---------------- stage 1: per-group encoders ----------------
    logic [N_GRP-1:0]  grp_any_w;
    logic [N_GRP-1:0]  grp_mult_w;
    logic [LIDX_W-1:0] grp_lidx_w [N_GRP];

    generate
        for (genvar g = 0; g < N_GRP; g++) begin : g_grp
            encode8_3 u_enc (
                .grp   (in_vec[g*GROUP +: GROUP]),
                .any   (grp_any_w[g]),
                .lidx  (grp_lidx_w[g]),
                .multi (grp_mult_w[g])
            );
        end
    endgenerate

    logic     s1_valid_q, s1_valid_d;
    grp_enc_t s1_grp_q [N_GRP];
    grp_enc_t s1_grp_d [N_GRP];

    logic             s2_valid_q, s2_valid_d;
    idx_t             out_idx_q, out_idx_d;
    logic             out_zero_q, out_zero_d;
    logic             out_multi_q, out_multi_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic s2_adv, s1_adv;

    // ---------------- flow control ----------------
    always_comb begin
        s2_adv   = ~s2_valid_q | out_ready;
        s1_adv   = ~s1_valid_q | s2_adv;
        in_ready = s1_adv;
    end

    // Stage-1 load: payload only changes on an actual input transfer
    always_comb begin
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        for (int g = 0; g < N_GRP; g++) begin
            s1_grp_d[g] = s1_grp_q[g];
            if (s1_adv && in_valid) begin
                s1_grp_d[g].any   = grp_any_w[g];
                s1_grp_d[g].lidx  = grp_lidx_w[g];
                s1_grp_d[g].gmult = grp_mult_w[g];
            end
        end
    end

    // ---------------- stage 2: combine groups ----------------
    logic              found_c;
    logic              second_c;
    logic              gmult_c;
    logic [GIDX_W-1:0] g0_c;
    logic [LIDX_W-1:0] lidx_c;

    always_comb begin
        found_c  = 1'b0;
        second_c = 1'b0;
        gmult_c  = 1'b0;
        g0_c     = '0;
        lidx_c   = '0;
        for (int g = 0; g < N_GRP; g++) begin
            if (s1_grp_q[g].gmult) begin
                gmult_c = 1'b1;
            end
            if (s1_grp_q[g].any) begin
                if (found_c) begin
                    second_c = 1'b1;   // a second non-empty group: multi-hot
                end else begin
                    found_c = 1'b1;
                    g0_c    = GIDX_W'(g);
                    lidx_c  = s1_grp_q[g].lidx;
                end
            end
        end
    end

    always_comb begin
        s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
        out_idx_d   = out_idx_q;
        out_zero_d  = out_zero_q;
        out_multi_d = out_multi_q;
        if (s2_adv && s1_valid_q) begin
            // g0*8 + lidx is a plain concatenation since GROUP is a power of two
            out_idx_d   = found_c ? {g0_c, lidx_c} : IDX_NONE;
            out_zero_d  = ~found_c;
            out_multi_d = gmult_c | second_c;
        end
    end

    // ---------------- error counter ----------------
    logic err_xfer_c;

    always_comb begin
        err_xfer_c = s2_valid_q & out_ready & (out_zero_q | out_multi_q);
        err_cnt_d  = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;               // clear wins over a same-cycle error
        end else if (err_xfer_c && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_idx_q   <= '0;
            out_zero_q  <= 1'b0;
            out_multi_q <= 1'b0;
            err_cnt_q   <= '0;
            for (int g = 0; g < N_GRP; g++) begin
                s1_grp_q[g] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_idx_q   <= out_idx_d;
            out_zero_q  <= out_zero_d;
            out_multi_q <= out_multi_d;
            err_cnt_q   <= err_cnt_d;
            for (int g = 0; g < N_GRP; g++) begin
                s1_grp_q[g] <= s1_grp_d[g];
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_idx   = out_idx_q;
    assign out_zero  = out_zero_q;
    assign out_multi = out_multi_q;
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_encode80_7.sv
`default_nettype none
// ============================================================================
// Module      : tb_encode80_7
// Description : Self-checking bench for encode80_7. A queue of expected
//               results (computed directly from the input vector) tracks
//               items in flight; outputs and in_ready are compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encode80_7;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [79:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_idx;
    logic        out_zero;
    logic        out_multi;
    logic        clr_err;
    logic [15:0] err_cnt;

    encode80_7 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_zero  (out_zero),
        .out_multi (out_multi),
        .clr_err   (clr_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] idx;
        logic       zero;
        logic       multi;
        int         age;     // clock edges since acceptance
    } exp_t;

    exp_t q[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   err_m      = 0;
    int   n_acc      = 0;
    int   n_err_xfer = 0;

    function automatic exp_t ref_enc(input logic [79:0] v);
        exp_t r;
        r.idx = 7'h7F;
        for (int k = 79; k >= 0; k--) begin
            if (v[k]) r.idx = 7'(k);
        end
        r.zero  = (v == 80'd0);
        r.multi = ($countones(v) > 1);
        r.age   = 0;
        return r;
    endfunction

    function automatic logic [79:0] onehot(input int k);
        logic [79:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs were set just after the previous falling edge.
    task automatic tick();
        logic exp_rdy, acc, ot, ev;
        exp_t e;
        #1;
        // Two items in flight means both stages are full
        exp_rdy = !(q.size() == 2 && !out_ready);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        acc = in_valid && exp_rdy;
        ot  = (q.size() > 0) && (q[0].age >= 2) && out_ready;
        e   = ref_enc(in_vec);
        @(posedge clk);
        if (clr_err) err_m = 0;
        else if (ot && (q[0].zero || q[0].multi) && err_m < 65535) err_m++;
        if (ot) begin
            if (q[0].zero || q[0].multi) n_err_xfer++;
            void'(q.pop_front());
        end
        foreach (q[i]) q[i].age++;
        if (acc) begin
            e.age = 1;
            q.push_back(e);
            n_acc++;
        end
        @(negedge clk);
        ev = (q.size() > 0) && (q[0].age >= 2);
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        if (ev) begin
            chk("out_idx",   {25'd0, out_idx},   {25'd0, q[0].idx});
            chk("out_zero",  {31'd0, out_zero},  {31'd0, q[0].zero});
            chk("out_multi", {31'd0, out_multi}, {31'd0, q[0].multi});
        end
        chk("err_cnt", {16'd0, err_cnt}, 32'(err_m));
    endtask

    task automatic drain();
        int bound;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bound = 0;
        while (q.size() > 0 && bound < 10) begin
            tick();
            bound++;
        end
        chk("drain_bound", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int acc0;
        int base;
        int bound;
        logic [6:0]  held_idx;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_idx",   {25'd0, out_idx},   32'd0);
        chk("rst_out_zero",  {31'd0, out_zero},  32'd0);
        chk("rst_out_multi", {31'd0, out_multi}, 32'd0);
        chk("rst_err_cnt",   {16'd0, err_cnt},   32'd0);
        rst_n = 1'b1;

        // 1. Round trip over every index, back to back
        in_valid = 1'b1;
        for (int k = 0; k < 80; k++) begin
            in_vec = onehot(k);
            tick();
        end
        drain();
        chk("roundtrip_err", {16'd0, err_cnt}, 32'd0);

        // 2. Zero input
        in_valid = 1'b1;
        in_vec   = '0;
        tick();
        drain();
        chk("zero_err", {16'd0, err_cnt}, 32'd1);

        // 3. Multi-hot across groups and within a group
        in_valid = 1'b1;
        in_vec   = onehot(5) | onehot(70);
        tick();
        in_vec   = onehot(3) | onehot(4);
        tick();
        drain();
        chk("multi_err", {16'd0, err_cnt}, 32'd3);

        // 4. Backpressure: only two items fit while the output is stalled
        acc0      = n_acc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_vec = onehot(10 + n_acc - acc0);
            tick();
            if (c == 2) held_idx = out_idx;
        end
        chk("bp_accepted", 32'(n_acc - acc0), 32'd2);
        chk("bp_stable", {25'd0, out_idx}, {25'd0, held_idx});
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_vec = onehot(10 + n_acc - acc0);
            tick();
        end
        drain();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_err   = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 3))
                0: in_vec = onehot($urandom_range(0, 79));
                1: in_vec = '0;
                2: in_vec = onehot($urandom_range(0, 79)) | onehot($urandom_range(0, 79));
                default: in_vec = {$urandom(), $urandom(), $urandom()};
            endcase
            tick();
        end
        clr_err = 1'b0;
        drain();

        // 5. Saturation then clear racing an error transfer
        base      = n_err_xfer;
        in_valid  = 1'b1;
        in_vec    = '0;
        out_ready = 1'b1;
        bound     = 0;
        while ((n_err_xfer - base) < 65537 && bound < 70000) begin
            tick();
            bound++;
        end
        chk("sat_bound", 32'(n_err_xfer - base), 32'd65537);
        chk("sat_value", {16'd0, err_cnt}, 32'h0000FFFF);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_wins", {16'd0, err_cnt}, 32'd0);
        drain();

        // 6. Reset mid-stream with both stages occupied
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = onehot(20);
        tick();
        in_vec    = onehot(21);
        tick();
        in_valid  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_idx",   {25'd0, out_idx},   32'd0);
        q.delete();
        err_m = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_vec    = onehot(42);
        tick();
        in_valid  = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
